bcd_wrap_counter: RTL

Parametrised multi-digit BCD up/down counter with two selectable wrap limits, parallel load, wrap/saturate mode and registered carry/borrow pulses. It generalises the single-digit time-field counters in the clock/timer datapath: one instance replaces a cascaded digit pair (e.g. hours 00–23 / 00–11, minutes 00–59). It sits between the key-debounce/one-pulse logic and the seven-segment display scan. Its carry and borrow pulses feed the next-higher field.

---
 rtl/bcd_wrap_counter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/bcd_wrap_counter.sv
// Multi-digit packed-BCD up/down counter with selectable wrap limit, load and wrap/saturate mode.
// Latency 1 cycle from request to value/pulses; no backpressure, every request is acted on.
module bcd_wrap_counter #(
   parameter int                  DIGITS    = 2,
   parameter logic [4*DIGITS-1:0] LIMIT     = 'h23,
   parameter logic [4*DIGITS-1:0] ALT_LIMIT = 'h11
) (
   input  logic                  clk_out,
   input  logic                  rst,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_value,
   input  logic                  limit_sel,
   input  logic                  wrap_en,
   output logic [4*DIGITS-1:0]   value,
   output logic                  carry,
   output logic                  borrow,
   output logic                  load_err,
   output logic                  at_zero
);

   localparam int W = 4 * DIGITS;

   function automatic logic bcd_ok(input logic [W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (c) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         b;
      r = v;
      b = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (b) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               b = 1'b0;
            end
         end
      end
      return r;
   endfunction

   logic [W-1:0] lim;
   logic [W-1:0] value_nxt;
   logic         carry_nxt;
   logic         borrow_nxt;
   logic         load_err_nxt;

   assign lim     = limit_sel ? ALT_LIMIT : LIMIT;
   assign at_zero = (value == '0);

   // Packed BCD orders like plain binary, so all bound checks are direct vector compares.
   always_comb begin
      value_nxt    = value;
      carry_nxt    = 1'b0;
      borrow_nxt   = 1'b0;
      load_err_nxt = 1'b0;
      if (load) begin
         if (bcd_ok(load_value) && (load_value <= lim)) value_nxt = load_value;
         else load_err_nxt = 1'b1;
      end else if (dec) begin
         if (value != '0) begin
            value_nxt = bcd_dec(value);
         end else if (wrap_en) begin
            value_nxt  = lim;
            borrow_nxt = 1'b1;
         end
      end else if (inc) begin
         if (value < lim) begin
            value_nxt = bcd_inc(value);
         end else if (wrap_en) begin
            value_nxt = '0;
            carry_nxt = 1'b1;
         end
      end else if (value > lim) begin
         value_nxt = '0;
      end
   end

   always_ff @(posedge clk_out) begin
      if (rst) begin
         value    <= '0;
         carry    <= 1'b0;
         borrow   <= 1'b0;
         load_err <= 1'b0;
      end else begin
         value    <= value_nxt;
         carry    <= carry_nxt;
         borrow   <= borrow_nxt;
         load_err <= load_err_nxt;
      end
   end

   always_ff @(posedge clk_out) begin
      assert ((DIGITS >= 1) && (DIGITS <= 4) && bcd_ok(LIMIT) && bcd_ok(ALT_LIMIT))
         else $error("bcd_wrap_counter: illegal DIGITS or non-BCD limit parameter");
   end

endmodule
